// File: rtl/wide_addsub_seq_pkg.sv
// Shared types and constants for the word-serial wide add/subtract sequencer.
// Also holds the 4-bit lookahead carry function used at both levels of the CLA slice.
package wide_addsub_seq_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned WORDS  = 4;
  localparam int unsigned W      = WORD_W * WORDS;
  localparam int unsigned IDX_W  = $clog2(WORDS);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Returns carries c[0..4] for a 4-bit group as flat sum-of-products,
  // so no carry ripples through the group.
  function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                      input logic c);
    logic [4:0] cy;
    logic       t;
    cy[0] = c;
    for (int j = 1; j <= 4; j++) begin
      t = c;
      for (int k = 0; k < j; k++) t = t & p[k];
      cy[j] = t;
      for (int m = 0; m < j; m++) begin
        t = g[m];
        for (int k = m + 1; k < j; k++) t = t & p[k];
        cy[j] = cy[j] | t;
      end
    end
    return cy;
  endfunction

endpackage

// File: rtl/wide_addsub_seq_if.sv
// Request/result bundle between a requesting datapath (master) and the
// wide add/subtract sequencer (slave).
import wide_addsub_seq_pkg::*;

interface wide_addsub_seq_if;
  logic         start;
  logic         op_sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, op_sub, cin, a, b,
    input  ready, done, sum, cout, ovf
  );

  modport slave (
    input  start, op_sub, cin, a, b,
    output ready, done, sum, cout, ovf
  );
endinterface

// File: rtl/wide_addsub_seq_cla.sv
// 16-bit two-level carry-lookahead adder slice: four 4-bit groups whose
// carries come from a second lookahead stage over group generate/propagate.
module CLA_16_bit
  import wide_addsub_seq_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o,
  output logic        pout_o,
  output logic        gout_o
);

  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] c;
  logic [3:0]  bp;
  logic [3:0]  bg;
  logic [4:0]  bc;

  always_comb begin : comb_cla
    logic [4:0] lc;
    p  = a_i ^ b_i;
    g  = a_i & b_i;
    bp = '0;
    bg = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      lc    = cla4(g[4*k +: 4], p[4*k +: 4], 1'b0);
      bg[k] = lc[4];
      bp[k] = &p[4*k +: 4];
    end
    bc = cla4(bg, bp, cin_i);
    for (int k = 0; k < 4; k++) begin
      lc           = cla4(g[4*k +: 4], p[4*k +: 4], bc[k]);
      c[4*k +: 4]  = lc[3:0];
    end
    lc     = cla4(bg, bp, 1'b0);
    gout_o = lc[4];
    pout_o = &bp;
    sum_o  = p ^ c;
    cout_o = bc[4];
  end

endmodule

// File: rtl/wide_addsub_seq.sv
// Word-serial wide add/subtract: one shared CLA_16_bit slice processes the
// operand least-significant word first, with the inter-word carry registered.
module wide_addsub_seq
  import wide_addsub_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  wide_addsub_seq_if.slave  bus
);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [W-1:0]       opa_q;
  logic [W-1:0]       opb_q;
  logic [W-1:0]       sum_q;
  logic               cout_q;
  logic               ovf_q;
  logic               ready_q;
  logic               done_q;

  logic [WORD_W-1:0]  opa_word_d;
  logic [WORD_W-1:0]  opb_word_d;
  logic [WORD_W-1:0]  slice_sum_d;
  logic               slice_cout_d;
  logic               unused_pout;
  logic               unused_gout;

  always_comb begin
    opa_word_d = opa_q[idx_q*WORD_W +: WORD_W];
    opb_word_d = opb_q[idx_q*WORD_W +: WORD_W];
  end

  CLA_16_bit u_slice (
    .a_i    (opa_word_d),
    .b_i    (opb_word_d),
    .cin_i  (carry_q),
    .sum_o  (slice_sum_d),
    .cout_o (slice_cout_d),
    .pout_o (unused_pout),
    .gout_o (unused_gout)
  );

  // NOTE: all state here updates with <= so every register samples the
  // pre-edge values of the others; blocking assignments would chain them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            // NOTE: opa_q/opb_q carry no reset; they are always loaded here
            // before any cycle that reads them.
            opa_q   <= bus.a;
            opb_q   <= bus.op_sub ? ~bus.b : bus.b;
            carry_q <= bus.op_sub ? 1'b1 : bus.cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q[idx_q*WORD_W +: WORD_W] <= slice_sum_d;
          carry_q <= slice_cout_d;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            // Top word is being written now, so its sign bit is the slice's.
            cout_q  <= slice_cout_d;
            ovf_q   <= (opa_q[W-1] == opb_q[W-1]) &&
                       (slice_sum_d[WORD_W-1] != opa_q[W-1]);
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;

endmodule
